fanin_resp_l2_rr_buf: RTL and testbench
=======================================

Name: fanin_resp_l2_rr_buf

Overview:
N-channel response fan-in for the L2 crossbar return path. It merges N slave-side read-response streams onto one master-side response port. Simultaneous responses are buffered in small per-channel FIFOs instead of being silently overwritten. One response is issued per cycle under round-robin arbitration, through a registered output carrying the source channel index.

Parameters:
N_CH, 4, number of input response channels (>=2)
DATA_WIDTH, 64, response data width
FIFO_DEPTH, 2, entries per channel buffer (>=1; power of two not required)
ID_WIDTH, $clog2(N_CH), derived; width of source index output

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
data_r_rdata_i  in  N_CH*DATA_WIDTH  per-channel response data; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
data_r_valid_i  in  N_CH  per-channel response valid (single-cycle pulses, no backpressure)
data_r_rdata_o  out  DATA_WIDTH  merged response data (registered)
data_r_valid_o  out  1  merged response valid (registered)
data_r_id_o  out  ID_WIDTH  channel index of current output response (registered)
busy_o  out  1  high while any channel FIFO is non-empty
overflow_o  out  1  sticky: a response was dropped
overflow_ch_o  out  N_CH  sticky per-channel drop bitmap
clear_err_i  in  1  synchronous clear of overflow_o / overflow_ch_o

Behaviour:
- Reset (rst_n low, asynchronous): all FIFOs empty, pointers 0, RR pointer = 0, data_r_valid_o=0, data_r_rdata_o=0, data_r_id_o=0, overflow_o=0, overflow_ch_o=0. Reset mid-burst discards all buffered responses.
- Candidate per channel k: FIFO head if FIFO k non-empty; otherwise the live input if data_r_valid_i[k]=1 (bypass). A channel's live input never overtakes its own buffered entries; per-channel order is preserved.
- Arbitration: combinational round-robin over candidates, starting search at RR pointer. Winner w is registered at the next rising edge: data_r_valid_o=1, data_r_rdata_o=candidate data, data_r_id_o=w. RR pointer <= (w+1) mod N_CH. No candidate: data_r_valid_o=0, data_r_rdata_o and data_r_id_o hold their last values, RR pointer unchanged.
- Latency: response on an idle system appears on the output exactly 1 cycle after its input valid.
- FIFO update per channel per cycle:
  - Winner from FIFO head: pop.
  - Live valid not consumed by bypass: push.
  - Simultaneous pop and push on a full FIFO: allowed, no drop.
  - Push to a full FIFO with no pop in that cycle: data dropped, overflow_ch_o[k] <= 1, overflow_o <= 1.
- Throughput: exactly one output per cycle while any candidate exists. Sustained aggregate input rate >1/cycle eventually overflows. This is by design; overflow flags report it.
- busy_o = OR of FIFO non-empty flags (combinational from state).
- clear_err_i: clears both sticky flags at the next edge. If a new drop occurs in the same cycle, set wins.
- With N_CH=2, FIFO_DEPTH≥1 and mutually exclusive valids, output matches the legacy 2:1 fan-in delayed by one cycle.

Test Plan:
- Single response: reset, then valid_i=4'b0100 with data 0xA5A5 for one cycle -> next cycle valid_o=1, rdata_o=0xA5A5, id_o=2; following cycle valid_o=0; busy_o never high.
- Full collision, N_CH=4, DEPTH=2: all four valid in one cycle with data 0x10,0x11,0x12,0x13, RR=0 -> outputs on 4 consecutive cycles with id 0,1,2,3; busy_o high for 3 cycles; no overflow.
- Round-robin fairness: channels 0 and 3 valid every cycle for 6 cycles, DEPTH=4 -> output ids alternate 0,3,0,3,...; per-channel data emitted in input order; no drops.
- Overflow: channels 0,1 valid every cycle for 8 cycles with DEPTH=2 -> overflow_o=1, and overflow_ch_o marks exactly the channel whose push found its FIFO full with no pop; every non-dropped datum appears exactly once, in order.
- Error clear: after overflow, pulse clear_err_i with no input traffic -> flags 0 next cycle. Repeat with a new drop in the same cycle -> flags remain 1.
- Reset mid-operation: 3 entries buffered, assert rst_n low between edges -> valid_o=0 and busy_o=0 immediately. After release, no stale response is emitted.

Source files
------------

// File: rtl/fanin_resp_l2_rr_buf_if.sv
// Response-path bundle for the L2 return fan-in: N slave-side streams in, one merged stream out.
// The slave modport is the fan-in block; the master modport is whoever drives the inputs.
interface fanin_resp_l2_rr_buf_if #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = $clog2(N_CH)
);
  logic [N_CH*DATA_WIDTH-1:0] data_r_rdata_i;
  logic [N_CH-1:0]            data_r_valid_i;
  logic                       clear_err_i;
  logic [DATA_WIDTH-1:0]      data_r_rdata_o;
  logic                       data_r_valid_o;
  logic [ID_WIDTH-1:0]        data_r_id_o;
  logic                       busy_o;
  logic                       overflow_o;
  logic [N_CH-1:0]            overflow_ch_o;

  modport slave (
    input  data_r_rdata_i, data_r_valid_i, clear_err_i,
    output data_r_rdata_o, data_r_valid_o, data_r_id_o, busy_o, overflow_o, overflow_ch_o
  );

  modport master (
    output data_r_rdata_i, data_r_valid_i, clear_err_i,
    input  data_r_rdata_o, data_r_valid_o, data_r_id_o, busy_o, overflow_o, overflow_ch_o
  );
endinterface

// File: rtl/fanin_resp_l2_rr_buf.sv
// N-channel read-response fan-in with per-channel buffering and round-robin arbitration.
// One response leaves per cycle through a registered output that also carries the source channel.
module fanin_resp_l2_rr_buf #(
  parameter int N_CH       = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 2,
  parameter int ID_WIDTH   = $clog2(N_CH)
) (
  input logic                   clk,
  input logic                   rst_n,
  fanin_resp_l2_rr_buf_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr [N_CH];
  logic [PTR_W-1:0]      wr_ptr [N_CH];
  logic [CNT_W-1:0]      count  [N_CH];
  logic [ID_WIDTH-1:0]   rr_ptr;

  logic [DATA_WIDTH-1:0] live_data [N_CH];
  logic [DATA_WIDTH-1:0] cand_data [N_CH];
  logic [N_CH-1:0]       fifo_empty, fifo_full, cand_valid;
  logic [N_CH-1:0]       pop, wr_en, drop;
  logic                  grant_any;
  logic [ID_WIDTH-1:0]   grant_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A buffered head always takes precedence over the live input, which keeps per-channel order.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      live_data[k]  = bus.data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      fifo_empty[k] = (count[k] == '0);
      fifo_full[k]  = (count[k] == CNT_W'(FIFO_DEPTH));
      cand_valid[k] = !fifo_empty[k] || bus.data_r_valid_i[k];
      cand_data[k]  = fifo_empty[k] ? live_data[k] : mem[k][rd_ptr[k]];
    end
  end

  // Scan from the farthest offset down so the channel nearest rr_ptr is the last writer and wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (cand_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      logic won, push;
      won      = grant_any && (grant_id == ID_WIDTH'(k));
      pop[k]   = won && !fifo_empty[k];
      push     = bus.data_r_valid_i[k] && !(won && fifo_empty[k]);
      drop[k]  = push && fifo_full[k] && !pop[k];
      wr_en[k] = push && !drop[k];
    end
  end

  // NOTE: the buffer storage has no reset; occupancy is tracked by the reset counters, so stale
  // contents are never read and the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (wr_en[k]) mem[k][wr_ptr[k]] <= live_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
      rr_ptr             <= '0;
      bus.data_r_valid_o <= 1'b0;
      bus.data_r_rdata_o <= '0;
      bus.data_r_id_o    <= '0;
      bus.overflow_o     <= 1'b0;
      bus.overflow_ch_o  <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (pop[k])   rd_ptr[k] <= ptr_inc(rd_ptr[k]);
        if (wr_en[k]) wr_ptr[k] <= ptr_inc(wr_ptr[k]);
        if (wr_en[k] && !pop[k])      count[k] <= count[k] + 1'b1;
        else if (!wr_en[k] && pop[k]) count[k] <= count[k] - 1'b1;
      end

      bus.data_r_valid_o <= grant_any;
      if (grant_any) begin
        bus.data_r_rdata_o <= cand_data[grant_id];
        bus.data_r_id_o    <= grant_id;
        rr_ptr <= (grant_id == ID_WIDTH'(N_CH - 1)) ? '0 : grant_id + 1'b1;
      end

      // A drop in the same cycle as a clear still leaves the flag set.
      bus.overflow_ch_o <= (bus.clear_err_i ? '0 : bus.overflow_ch_o) | drop;
      bus.overflow_o    <= (bus.clear_err_i ? 1'b0 : bus.overflow_o) | (|drop);
    end
  end

  assign bus.busy_o = ~&fifo_empty;

endmodule

// File: tb/tb_fanin_resp_l2_rr_buf.sv
// Bench for fanin_resp_l2_rr_buf: queue-based reference model feeds a scoreboard that a
// free-running monitor drains on every falling edge.
module tb_fanin_resp_l2_rr_buf;
  localparam int N_CH  = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 2;
  localparam int ID_W  = $clog2(N_CH);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fanin_resp_l2_rr_buf_if #(.N_CH(N_CH), .DATA_WIDTH(DW)) bus ();

  fanin_resp_l2_rr_buf #(.N_CH(N_CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Stimulus currently applied to the DUT.
  logic [N_CH-1:0] s_valid = '0;
  logic [DW-1:0]   s_data [N_CH];
  logic            s_clr = 1'b0;

  // Reference model: one queue per channel holds everything accepted but not yet emitted.
  logic [DW-1:0]   mq [N_CH][$];
  int              m_rr = 0;
  resp_t           exp_q [$];
  logic            exp_busy = 1'b0;
  logic            exp_ovf = 1'b0;
  logic [N_CH-1:0] exp_ovf_ch = '0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) mq[k].delete();
    m_rr = 0;
    exp_q.delete();
    exp_busy = 1'b0;
    exp_ovf = 1'b0;
    exp_ovf_ch = '0;
  endtask

  // New arrivals join the tail of their channel; the first non-empty channel from the RR pointer
  // emits its oldest item; anything left beyond DEPTH is the newest arrival and is lost.
  task automatic model_step();
    logic [N_CH-1:0] dropped;
    int w;
    dropped = '0;
    w = -1;
    for (int k = 0; k < N_CH; k++)
      if (s_valid[k]) mq[k].push_back(s_data[k]);
    for (int i = 0; i < N_CH; i++) begin
      int c;
      c = (m_rr + i) % N_CH;
      if (w < 0 && mq[c].size() > 0) w = c;
    end
    if (w >= 0) begin
      resp_t r;
      r.id   = ID_W'(w);
      r.data = mq[w].pop_front();
      exp_q.push_back(r);
      m_rr = (w + 1) % N_CH;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (mq[k].size() > DEPTH) begin
        void'(mq[k].pop_back());
        dropped[k] = 1'b1;
      end
    end
    exp_ovf_ch = (s_clr ? '0 : exp_ovf_ch) | dropped;
    exp_ovf    = (s_clr ? 1'b0 : exp_ovf) | (|dropped);
    exp_busy   = 1'b0;
    for (int k = 0; k < N_CH; k++)
      if (mq[k].size() > 0) exp_busy = 1'b1;
  endtask

  // Apply one cycle of stimulus; the model advances on the same rising edge as the DUT.
  task automatic step(input logic [N_CH-1:0] v, input logic clr);
    s_valid = v;
    s_clr   = clr;
    bus.data_r_valid_i = v;
    bus.clear_err_i    = clr;
    for (int k = 0; k < N_CH; k++) bus.data_r_rdata_i[k*DW +: DW] = s_data[k];
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N_CH; k++) s_data[k] = {$urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask

  // Monitor: every falling edge, the registered output must match the next scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.data_r_valid_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid_o", 1, 0);
          end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("id_o", DW'(bus.data_r_id_o), DW'(e.id));
            check("rdata_o", bus.data_r_rdata_o, e.data);
          end
        end else if (exp_q.size() != 0) begin
          check("missing_valid_o", 0, 1);
          void'(exp_q.pop_front());
        end
        check("busy_o", DW'(bus.busy_o), DW'(exp_busy));
        check("overflow_o", DW'(bus.overflow_o), DW'(exp_ovf));
        check("overflow_ch_o", DW'(bus.overflow_ch_o), DW'(exp_ovf_ch));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < N_CH; k++) s_data[k] = '0;
    bus.data_r_valid_i = '0;
    bus.data_r_rdata_i = '0;
    bus.clear_err_i    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("reset_valid_o", DW'(bus.data_r_valid_o), 0);
    check("reset_rdata_o", bus.data_r_rdata_o, 0);
    check("reset_id_o", DW'(bus.data_r_id_o), 0);
    check("reset_busy_o", DW'(bus.busy_o), 0);
    check("reset_overflow_o", DW'(bus.overflow_o), 0);
    check("reset_overflow_ch_o", DW'(bus.overflow_ch_o), 0);

    // Single response on channel 2.
    s_data[2] = 64'hA5A5;
    step(4'b0100, 1'b0);
    idle(3);

    // Full collision: all four channels in one cycle.
    for (int k = 0; k < N_CH; k++) s_data[k] = 64'h10 + DW'(k);
    step(4'b1111, 1'b0);
    idle(6);

    // Two channels contending every cycle.
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step(4'b1001, 1'b0);
    end
    idle(8);

    // Sustained overload on channels 0 and 1.
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step(4'b0011, 1'b0);
    end
    idle(8);
    check("overflow_seen", DW'(bus.overflow_o), 1);

    // Clear with no traffic, then clear coinciding with a fresh drop.
    step('0, 1'b1);
    idle(1);
    check("cleared_overflow_o", DW'(bus.overflow_o), 0);
    for (int i = 0; i < 4; i++) begin
      rand_data();
      step(4'b1111, 1'b0);
    end
    rand_data();
    step(4'b1111, 1'b1);
    check("set_wins_overflow_o", DW'(bus.overflow_o), 1);
    idle(12);
    step('0, 1'b1);

    // Reset in the middle of a burst: three entries buffered.
    rand_data();
    step(4'b1111, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("midreset_valid_o", DW'(bus.data_r_valid_o), 0);
    check("midreset_busy_o", DW'(bus.busy_o), 0);
    check("midreset_rdata_o", bus.data_r_rdata_o, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(6);

    // Randomised traffic at varying load.
    for (int blk = 0; blk < 16; blk++) begin
      int p;
      p = (blk % 4 == 0) ? 10 : (blk % 4 == 1) ? 30 : (blk % 4 == 2) ? 55 : 90;
      for (int i = 0; i < 100; i++) begin
        logic [N_CH-1:0] v;
        for (int k = 0; k < N_CH; k++) v[k] = ($urandom_range(99) < p);
        rand_data();
        step(v, $urandom_range(99) < 4);
      end
      idle(N_CH * DEPTH + 2);
    end

    idle(4);
    check("scoreboard_drained", DW'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
